// File: rtl/uart_bus_sequencer.sv
// Sequences a 16550-style UART register bus: one-shot line/FIFO configuration,
// then round-robin service of a TX byte client and an RX polling client.
//
// state  | meaning
// IDLE   | waiting for start, bus quiet
// CFG    | issuing the five configuration writes, one per cycle
// ARB    | picking the next TX write or RX poll
// WR     | single-cycle THR write of the latched TX byte
// RD_LSR | 3-cycle read of LSR, data-ready decides what follows
// RD_RHR | 3-cycle read of RHR, result handed to the RX client
module uart_bus_sequencer #(
    parameter logic [15:0] DIV     = 16'd27,
    parameter logic [7:0]  LCR_CFG = 8'h03,
    parameter logic [7:0]  FCR_CFG = 8'h07
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       cfg_done,
    output logic       busy,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       tx_full,
    input  logic       rx_req,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic [3:0] rx_status,
    output logic       rx_empty,
    output logic       bus_wr,
    output logic       bus_rd,
    output logic [2:0] bus_addr,
    output logic [7:0] bus_din,
    input  logic [7:0] bus_dout
);

    typedef enum logic [2:0] {IDLE, CFG, ARB, WR, RD_LSR, RD_RHR} state_t;

    localparam logic [2:0] ADDR_RHR = 3'd0;
    localparam logic [2:0] ADDR_LSR = 3'd5;

    state_t     state;
    logic [2:0] step;
    logic       last_tx;
    logic [3:0] lsr_err;

    logic tx_cand, rx_cand, grant_tx, grant_rx;

    // {addr, data} of configuration write number idx; DLAB is set by the first LCR write
    function automatic logic [10:0] cfg_word(input logic [2:0] idx);
        case (idx)
            3'd0:    cfg_word = {3'd3, 8'h80 | LCR_CFG};
            3'd1:    cfg_word = {3'd0, DIV[7:0]};
            3'd2:    cfg_word = {3'd1, DIV[15:8]};
            3'd3:    cfg_word = {3'd3, LCR_CFG & 8'h7F};
            3'd4:    cfg_word = {3'd2, FCR_CFG};
            default: cfg_word = 11'd0;
        endcase
    endfunction

    assign tx_cand  = tx_valid & ~tx_full;
    assign rx_cand  = rx_req;
    assign grant_tx = (state == ARB) & tx_cand & (~rx_cand | ~last_tx);
    assign grant_rx = (state == ARB) & rx_cand & (~tx_cand | last_tx);
    assign tx_ready = grant_tx;
    assign busy     = (state != IDLE) && (state != ARB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            step      <= 3'd0;
            last_tx   <= 1'b0;
            lsr_err   <= 4'd0;
            cfg_done  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= 8'd0;
            rx_status <= 4'd0;
            rx_empty  <= 1'b0;
            bus_wr    <= 1'b0;
            bus_rd    <= 1'b0;
            bus_addr  <= 3'd0;
            bus_din   <= 8'd0;
        end else begin
            rx_valid <= 1'b0;
            rx_empty <= 1'b0;
            case (state)
                IDLE, ARB: begin
                    if (grant_tx) begin
                        state    <= WR;
                        last_tx  <= 1'b1;
                        bus_wr   <= 1'b1;
                        bus_addr <= ADDR_RHR;
                        bus_din  <= tx_data;
                    end else if (grant_rx) begin
                        state    <= RD_LSR;
                        last_tx  <= 1'b0;
                        step     <= 3'd0;
                        bus_rd   <= 1'b1;
                        bus_addr <= ADDR_LSR;
                    end else if (start) begin
                        state               <= CFG;
                        cfg_done            <= 1'b0;
                        step                <= 3'd0;
                        bus_wr              <= 1'b1;
                        {bus_addr, bus_din} <= cfg_word(3'd0);
                    end
                end
                CFG: begin
                    if (step == 3'd4) begin
                        state    <= ARB;
                        step     <= 3'd0;
                        cfg_done <= 1'b1;
                        bus_wr   <= 1'b0;
                        bus_addr <= 3'd0;
                        bus_din  <= 8'd0;
                    end else begin
                        step                <= step + 3'd1;
                        {bus_addr, bus_din} <= cfg_word(step + 3'd1);
                    end
                end
                WR: begin
                    state    <= ARB;
                    bus_wr   <= 1'b0;
                    bus_addr <= 3'd0;
                    bus_din  <= 8'd0;
                end
                RD_LSR: begin
                    bus_rd <= 1'b0;
                    if (step == 3'd2) begin
                        step <= 3'd0;
                        if (bus_dout[0]) begin
                            state    <= RD_RHR;
                            lsr_err  <= bus_dout[4:1];
                            bus_rd   <= 1'b1;
                            bus_addr <= ADDR_RHR;
                        end else begin
                            state    <= ARB;
                            rx_empty <= 1'b1;
                            bus_addr <= 3'd0;
                        end
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                RD_RHR: begin
                    bus_rd <= 1'b0;
                    if (step == 3'd2) begin
                        state     <= ARB;
                        step      <= 3'd0;
                        rx_data   <= bus_dout;
                        rx_status <= lsr_err;
                        rx_valid  <= 1'b1;
                        bus_addr  <= 3'd0;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus_wr   <= 1'b0;
                    bus_rd   <= 1'b0;
                    bus_addr <= 3'd0;
                    bus_din  <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_sequencer.sv
// Scoreboard bench for uart_bus_sequencer: stimulus tasks queue expected bus and
// client events, a negedge monitor pops and compares them with their cycle spacing.
module tb_uart_bus_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, tx_valid, tx_full, rx_req;
    logic [7:0] tx_data;
    logic [7:0] bus_dout;
    logic       cfg_done, busy, tx_ready, rx_valid, rx_empty, bus_wr, bus_rd;
    logic [7:0] rx_data, bus_din;
    logic [3:0] rx_status;
    logic [2:0] bus_addr;

    uart_bus_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .cfg_done(cfg_done), .busy(busy),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_full(tx_full),
        .rx_req(rx_req), .rx_valid(rx_valid), .rx_data(rx_data), .rx_status(rx_status),
        .rx_empty(rx_empty), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_addr(bus_addr),
        .bus_din(bus_din), .bus_dout(bus_dout)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_WR, EV_RD, EV_TXR, EV_RXV, EV_RXE} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [2:0] addr;
        logic [7:0] data;
        logic [3:0] st;
        int         dly;   // cycles after the previous event, -1 = any
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] pair_q[$];          // {lsr, rhr} per RX poll, in grant order
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_ev_cyc = 0;
    bit          last_tx_m = 1'b0;   // model of the round-robin pointer

    task automatic push_ev(input ev_kind_t k, input logic [2:0] a, input logic [7:0] d,
                           input logic [3:0] s, input int dly);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.st = s; e.dly = dly;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input ev_kind_t k, input logic [2:0] a, input logic [7:0] d,
                            input logic [3:0] s);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%h st=%h at cycle %0d, expected none",
                     k, a, d, s, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.addr != a || e.data != d || e.st != s ||
                (e.dly >= 0 && (cyc - last_ev_cyc) != e.dly)) begin
                n_err++;
                $display("FAIL event_match: got kind=%0d addr=%0d data=%h st=%h gap=%0d, expected kind=%0d addr=%0d data=%h st=%h gap=%0d",
                         k, a, d, s, cyc - last_ev_cyc, e.kind, e.addr, e.data, e.st, e.dly);
            end
            last_ev_cyc = cyc;
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // monitor: bus rules every cycle, then events in a fixed within-cycle order
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                n_vec++;
                if ((bus_wr && bus_rd) ||
                    (!busy && (bus_wr || bus_rd || bus_addr != 3'd0 || bus_din != 8'd0))) begin
                    n_err++;
                    $display("FAIL bus_quiet: got wr=%b rd=%b addr=%0d din=%h busy=%b, expected no overlap and zero bus when not busy",
                             bus_wr, bus_rd, bus_addr, bus_din, busy);
                end
                if (rx_valid) check_ev(EV_RXV, 3'd0, rx_data, rx_status);
                if (rx_empty) check_ev(EV_RXE, 3'd0, 8'd0, 4'd0);
                if (tx_ready) check_ev(EV_TXR, 3'd0, tx_data, 4'd0);
                if (bus_wr)   check_ev(EV_WR, bus_addr, bus_din, 4'd0);
                if (bus_rd)   check_ev(EV_RD, bus_addr, 8'd0, 4'd0);
            end
        end
    end

    // register-file model: real data only in the third read cycle, inverted otherwise
    logic [7:0] cur_lsr = 8'd0;
    logic [7:0] cur_rhr = 8'd0;
    int         rd_cnt = 9;
    initial begin
        bus_dout = 8'd0;
        forever begin
            @(negedge clk);
            if (bus_rd) begin
                rd_cnt = 0;
                if (bus_addr == 3'd5 && pair_q.size() > 0) {cur_lsr, cur_rhr} = pair_q.pop_front();
            end else if (rd_cnt < 9) begin
                rd_cnt++;
            end
            if (rd_cnt == 2) bus_dout = (bus_addr == 3'd5) ? cur_lsr : cur_rhr;
            else             bus_dout = (bus_addr == 3'd5) ? ~cur_lsr : ~cur_rhr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() > 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_err++;
            $display("FAIL idle_timeout: got busy=%b pending=%0d, expected idle", busy, exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    task automatic configure();
        int n = 0;
        push_ev(EV_WR, 3'd3, 8'h83, 4'd0, -1);
        push_ev(EV_WR, 3'd0, 8'h1B, 4'd0, 1);
        push_ev(EV_WR, 3'd1, 8'h00, 4'd0, 1);
        push_ev(EV_WR, 3'd3, 8'h03, 4'd0, 1);
        push_ev(EV_WR, 3'd2, 8'h07, 4'd0, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("cfg_done_cleared", {62'd0, cfg_done, busy}, 64'h1);
        do begin
            @(negedge clk);
            n++;
        end while (!cfg_done && n < 20);
        check("cfg_done_latency", n, 6);
        tick();
    endtask

    task automatic do_tx(input logic [7:0] d, input int full_cycles);
        int n = 0;
        push_ev(EV_TXR, 3'd0, d, 4'd0, -1);
        push_ev(EV_WR, 3'd0, d, 4'd0, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        tx_full  = (full_cycles > 0);
        repeat (full_cycles) tick();
        tx_full = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_ready && n < 50);
        if (n >= 50) begin
            n_err++;
            $display("FAIL tx_timeout: got no tx_ready, expected grant");
        end
        tick();
        tx_valid  = 1'b0;
        last_tx_m = 1'b1;
        wait_idle();
    endtask

    task automatic push_rx(input logic [7:0] lsr, input logic [7:0] rhr);
        pair_q.push_back({lsr, rhr});
        push_ev(EV_RD, 3'd5, 8'd0, 4'd0, -1);
        if (lsr[0]) begin
            push_ev(EV_RD, 3'd0, 8'd0, 4'd0, 3);
            push_ev(EV_RXV, 3'd0, rhr, lsr[4:1], 3);
        end else begin
            push_ev(EV_RXE, 3'd0, 8'd0, 4'd0, 3);
        end
    endtask

    task automatic do_rx(input logic [7:0] lsr, input logic [7:0] rhr);
        int n = 0;
        push_rx(lsr, rhr);
        rx_req = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_rd && n < 50);
        if (n >= 50) begin
            n_err++;
            $display("FAIL rx_timeout: got no LSR read, expected grant");
        end
        tick();
        rx_req    = 1'b0;
        last_tx_m = 1'b0;
        wait_idle();
    endtask

    // both clients held; model predicts strict alternation from the last grant
    task automatic contention(input int n_grants, input bit full);
        logic [7:0] txb[$];
        int n_tx = 0, n_rx = 0, tx_cnt = 0, rx_cnt = 0, n = 0;
        bit nxt_tx, t, r;
        nxt_tx = !full && !last_tx_m;
        for (int i = 0; i < n_grants; i++) begin
            if (nxt_tx) begin
                txb.push_back(8'($urandom));
                push_ev(EV_TXR, 3'd0, txb[n_tx], 4'd0, -1);
                push_ev(EV_WR, 3'd0, txb[n_tx], 4'd0, 1);
                n_tx++;
            end else begin
                push_rx(8'($urandom) | 8'h01, 8'($urandom));
                n_rx++;
            end
            last_tx_m = nxt_tx;
            nxt_tx = !full && !nxt_tx;
        end
        tx_full  = full;
        tx_valid = full || (n_tx > 0);
        tx_data  = (n_tx > 0) ? txb[0] : 8'h00;
        rx_req   = (n_rx > 0);
        while ((tx_cnt < n_tx || rx_cnt < n_rx) && n < 200) begin
            @(negedge clk);
            t = tx_ready;
            r = bus_rd && bus_addr == 3'd5;
            tick();
            n++;
            if (t) begin
                tx_cnt++;
                if (tx_cnt >= n_tx) tx_valid = 1'b0;
                else tx_data = txb[tx_cnt];
            end
            if (r) begin
                rx_cnt++;
                if (rx_cnt >= n_rx) rx_req = 1'b0;
            end
        end
        if (n >= 200) begin
            n_err++;
            $display("FAIL contention_timeout: got tx=%0d rx=%0d grants, expected tx=%0d rx=%0d",
                     tx_cnt, rx_cnt, n_tx, n_rx);
        end
        tx_valid = 1'b0;
        tx_full  = 1'b0;
        rx_req   = 1'b0;
        wait_idle();
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; tx_valid = 1'b0; tx_full = 1'b0; rx_req = 1'b0; tx_data = 8'h00;
        repeat (3) tick();
        check("reset_outputs", {cfg_done, busy, tx_ready, rx_valid, rx_data, rx_status, rx_empty,
                                bus_wr, bus_rd, bus_addr, bus_din}, 64'd0);
        rst = 1'b0;
        repeat (5) tick();
        check("idle_no_cfg", {63'd0, cfg_done}, 64'd0);

        configure();
        do_tx(8'hA5, 0);
        do_rx(8'h61, 8'h3C);
        check("rx_hold_data", {rx_data, rx_status}, {52'd0, 8'h3C, 4'h0});
        do_rx(8'h60, 8'h11);
        check("rx_hold_after_empty", {rx_data, rx_status}, {52'd0, 8'h3C, 4'h0});
        contention(4, 1'b0);
        contention(2, 1'b1);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0:       do_tx(8'($urandom), int'($urandom_range(0, 3)));
                1:       do_rx(8'($urandom), 8'($urandom));
                default: contention(int'($urandom_range(2, 5)), 1'b0);
            endcase
        end

        configure();
        do_tx(8'h5C, 1);

        // reset during R1 of an LSR read
        push_rx(8'h61, 8'h3C);
        rx_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_rd && n < 50);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("reset_mid_read", {cfg_done, busy, tx_ready, rx_valid, rx_data, rx_status, rx_empty,
                                 bus_wr, bus_rd, bus_addr, bus_din}, 64'd0);
        exp_q.delete();
        pair_q.delete();
        last_tx_m = 1'b0;
        tx_valid  = 1'b1;
        tx_data   = 8'h77;
        tick();
        tick();
        rst = 1'b0;
        repeat (12) tick();
        check("post_reset_idle", {62'd0, cfg_done, busy}, 64'd0);
        tx_valid = 1'b0;
        rx_req   = 1'b0;
        tick();

        configure();
        contention(3, 1'b0);

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
